// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// -----------------------------------------------------------------------------
// PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xED set-LEDs,
// 0xFF reset) to a keyboard using the host request-to-send sequence:
//   1. hold the PS/2 clock low for INHIBIT_US,
//   2. pull data low (start bit) and release the clock,
//   3. let the device clock out d0..d7, odd parity and stop,
//   4. read the device ACK bit on the next falling clock,
//   5. wait for both lines to return high.
// Both PS/2 lines are open-drain: an *_oe_o output of 1 drives the pin low,
// 0 releases it to the external pull-up. This block shares the pins with the
// ps2kbd receiver; the receiver discards frames while busy_o is high.
//
// Handshake: a byte on data_i is accepted on a rising clk edge where
// valid_i && ready_o. ready_o is high only in IDLE, so valid_i is ignored
// while a frame is in flight; valid_i may be held high and the next byte is
// taken as soon as ready_o returns.
//
// Ports:
//   clk            system clock
//   reset_i        synchronous active-high reset
//   data_i[7:0]    command byte
//   valid_i        request to send data_i
//   ready_o        high in IDLE
//   busy_o         high whenever a frame is in progress
//   done_o         one-cycle pulse: frame sent and ACK (data low) received
//   err_o          one-cycle pulse: timeout, or ACK sampled high
//   ps2_clk_i      raw PS/2 clock pin level (asynchronous)
//   ps2_data_i     raw PS/2 data pin level (asynchronous)
//   ps2_clk_oe_o   1 = drive clock pin low, 0 = release
//   ps2_data_oe_o  1 = drive data pin low, 0 = release
// -----------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int unsigned FREQ_HZ    = 25_000_000,
    parameter int unsigned INHIBIT_US = 100,
    parameter int unsigned TIMEOUT_US = 15_000
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o
);

    localparam int unsigned CYC_PER_US = FREQ_HZ / 1_000_000;
    localparam int unsigned INH        = CYC_PER_US * INHIBIT_US;
    localparam int unsigned TMO        = CYC_PER_US * TIMEOUT_US;
    localparam int unsigned CNT_MAX    = (INH > TMO) ? INH : TMO;
    localparam int unsigned CW         = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] INH_LD  = CW'(INH);
    localparam logic [CW-1:0] TMO_LD  = CW'(TMO);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,  // clock held low for INH cycles
        ST_START     = 3'd2,  // clock still low, data low (start bit) for one cycle
        ST_SEND      = 3'd3,  // device clocks out start, d0..d7, parity, stop
        ST_ACK       = 3'd4,  // sample device ACK on the next fall
        ST_WAIT_IDLE = 3'd5   // wait for both lines high
    } state_t;

    // -------------------------------------------------------------------------
    // Line conditioning. Synchronizers reset to 1 (idle bus level) so that a
    // reset never manufactures a falling edge.
    // -------------------------------------------------------------------------
    logic clk_meta, clk_sync, clk_prev;
    logic data_meta, data_sync;
    logic fall;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_i;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data_i;
            data_sync <= data_meta;
        end
    end

    assign fall = clk_prev & ~clk_sync;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t        state_q,    state_d;
    logic [8:0]    shift_q,    shift_d;     // {parity, d7..d0}, shifted out LSB first
    logic [3:0]    bitcnt_q,   bitcnt_d;
    logic [CW-1:0] cnt_q,      cnt_d;       // shared inhibit / timeout down-counter
    logic          data_oe_q,  data_oe_d;
    logic          err_seen_q, err_seen_d;  // ACK error already reported this frame
    logic          done_pulse, err_pulse;
    logic          cnt_zero;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            cnt_q      <= '0;
            data_oe_q  <= 1'b0;
            err_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            cnt_q      <= cnt_d;
            data_oe_q  <= data_oe_d;
            err_seen_q <= err_seen_d;
        end
    end

    assign cnt_zero = (cnt_q == '0);

    // Timeout has priority over a coincident clock fall so that the line
    // release and err_o always happen in the same cycle.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        cnt_d      = cnt_q;
        data_oe_d  = data_oe_q;
        err_seen_d = err_seen_q;
        done_pulse = 1'b0;
        err_pulse  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                data_oe_d = 1'b0;
                if (valid_i) begin
                    shift_d    = {~^data_i, data_i};
                    cnt_d      = INH_LD;
                    bitcnt_d   = '0;
                    err_seen_d = 1'b0;
                    state_d    = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                // INHIBIT lasts INH cycles; START adds the last clock-low cycle
                // with data already low, giving INH+1 cycles of clock low.
                if (cnt_q <= CNT_ONE) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = ST_START;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_START: begin
                cnt_d    = TMO_LD;
                bitcnt_d = '0;
                state_d  = ST_SEND;
            end

            ST_SEND: begin
                if (cnt_zero) begin
                    data_oe_d = 1'b0;
                    err_pulse = 1'b1;
                    state_d   = ST_IDLE;
                end else if (fall) begin
                    cnt_d    = TMO_LD;
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q >= 4'd9) begin
                        // stop bit: release data, device will pull it for ACK
                        data_oe_d = 1'b0;
                        state_d   = ST_ACK;
                    end else begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[8:1]};
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_ACK: begin
                if (cnt_zero) begin
                    data_oe_d = 1'b0;
                    err_pulse = 1'b1;
                    state_d   = ST_IDLE;
                end else if (fall) begin
                    cnt_d   = TMO_LD;
                    state_d = ST_WAIT_IDLE;
                    if (data_sync) begin
                        err_pulse  = 1'b1;
                        err_seen_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_WAIT_IDLE: begin
                data_oe_d = 1'b0;
                if (cnt_zero) begin
                    // a NAK already produced this frame's single err pulse
                    err_pulse = ~err_seen_q;
                    state_d   = ST_IDLE;
                end else if (clk_sync && data_sync) begin
                    done_pulse = ~err_seen_q;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                data_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ready_o      = (state_q == ST_IDLE);
    assign busy_o       = (state_q != ST_IDLE);
    assign ps2_clk_oe_o = (state_q == ST_INHIBIT) || (state_q == ST_START);

    // Data is only ever driven from the start bit through the parity bit, and
    // is dropped in the very cycle a SEND timeout fires.
    assign ps2_data_oe_o = data_oe_q &&
                           ((state_q == ST_START) || ((state_q == ST_SEND) && !cnt_zero));

    // A reset sampled in the same cycle suppresses any pending pulse.
    assign done_o = done_pulse & ~reset_i;
    assign err_o  = err_pulse  & ~reset_i;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
// -----------------------------------------------------------------------------
// Bench for ps2_host_tx. The DUT runs at FREQ_HZ = 1 MHz so INH = 100 and
// TMO = 15_000 cycles; the device model clocks with a half period of HALF
// system cycles. Open-drain pins are modelled as a wired-AND of host and
// device pull-downs.
// -----------------------------------------------------------------------------
module tb_ps2_host_tx;

    localparam int unsigned TB_FREQ    = 1_000_000;
    localparam int unsigned TB_INH_US  = 100;
    localparam int unsigned TB_TMO_US  = 15_000;
    localparam int          INH        = (TB_FREQ / 1_000_000) * TB_INH_US;
    localparam int          TMO        = (TB_FREQ / 1_000_000) * TB_TMO_US;
    localparam int          HALF       = 40;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_i;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o, busy_o, done_o, err_o;
    logic       ps2_clk_i, ps2_data_i;
    logic       ps2_clk_oe_o, ps2_data_oe_o;
    logic       dev_clk_low, dev_data_low;

    assign ps2_clk_i  = ~(ps2_clk_oe_o  | dev_clk_low);
    assign ps2_data_i = ~(ps2_data_oe_o | dev_data_low);

    ps2_host_tx #(
        .FREQ_HZ   (TB_FREQ),
        .INHIBIT_US(TB_INH_US),
        .TIMEOUT_US(TB_TMO_US)
    ) dut (
        .clk          (clk),
        .reset_i      (reset_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .ps2_clk_i    (ps2_clk_i),
        .ps2_data_i   (ps2_data_i),
        .ps2_clk_oe_o (ps2_clk_oe_o),
        .ps2_data_oe_o(ps2_data_oe_o)
    );

    // ---------------- scoreboard ----------------
    logic [10:0] exp_q[$];   // expected frame {stop, parity, d7..d0, start}
    logic [1:0]  res_q[$];   // expected {done, err} pulse per frame
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int n_acc    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // cycle counter and accept tracker
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (valid_i && ready_o && !reset_i) begin
            acc_cyc = cyc;
            n_acc++;
        end
    end

    // result monitor: every done/err pulse must match the next expected result
    always @(negedge clk) begin
        if (done_o || err_o) begin
            logic [1:0] exp_res;
            exp_res = (res_q.size() != 0) ? res_q.pop_front() : 2'b00;
            check_eq("result_pulse", {30'b0, done_o, err_o}, {30'b0, exp_res});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input logic [1:0] res,
                             input bit push_bits, input bit push_res);
        int n = 0;
        @(negedge clk);
        while (!ready_o && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_before_send", {31'b0, ready_o}, 32'd1);
        data_i  = b;
        valid_i = 1'b1;
        if (push_bits) exp_q.push_back({1'b1, ~^b, b, 1'b0});
        if (push_res)  res_q.push_back(res);
        @(posedge clk);
        #1 valid_i = 1'b0;
    endtask

    // Waits for the inhibit window and measures it; returns at the first
    // negedge with the clock released.
    task automatic wait_release(output int hi, output int dcnt, output logic dlast);
        int n = 0;
        hi = 0; dcnt = 0; dlast = 1'b0;
        @(negedge clk);
        while (!ps2_clk_oe_o && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (ps2_clk_oe_o) check_eq("accept_lat", cyc - acc_cyc, 32'd0);
        while (ps2_clk_oe_o && hi < 10 * INH) begin
            hi++;
            dcnt  += int'(ps2_data_oe_o);
            dlast = ps2_data_oe_o;
            @(negedge clk);
        end
    endtask

    task automatic device_frame(input bit ack_high);
        int          hi, dcnt, n;
        logic        dlast;
        logic [10:0] bits;
        logic [31:0] exp;
        wait_release(hi, dcnt, dlast);
        check_eq("clk_oe_cycles", hi, INH + 1);
        check_eq("start_cycles", dcnt, 32'd1);
        check_eq("start_lead", {31'b0, dlast}, 32'd1);
        // start bit is read on the rising edge made by the host's release
        repeat (HALF / 2) @(negedge clk);
        bits[0] = ps2_data_i;
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (2) @(negedge clk);
            bits[i] = ps2_data_i;
            repeat (HALF - 2) @(negedge clk);
        end
        // ACK clock (fall 11)
        dev_data_low = ~ack_high;
        repeat (HALF / 2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (4) @(negedge clk);
        dev_data_low = 1'b0;
        exp = (exp_q.size() != 0) ? {21'b0, exp_q.pop_front()} : 32'hFFFF_FFFF;
        check_eq("frame_bits", {21'b0, bits}, exp);
        n = 0;
        while (!ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_after", {31'b0, ready_o}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   hi, dcnt, n, extra;
        logic dlast;
        reset_i = 1'b1; valid_i = 1'b0; data_i = 8'h00;
        dev_clk_low = 1'b0; dev_data_low = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", {31'b0, ready_o}, 32'd1);
        check_eq("rst_busy", {31'b0, busy_o}, 32'd0);
        check_eq("rst_pulses", {30'b0, done_o, err_o}, 32'd0);
        check_eq("rst_oe", {30'b0, ps2_clk_oe_o, ps2_data_oe_o}, 32'd0);

        // 0xED with ACK low
        send_byte(8'hED, 2'b10, 1, 1);
        device_frame(1'b0);

        // back-to-back 0xF4, 0x00 with valid_i held high
        fork
            begin
                @(negedge clk);
                data_i  = 8'hF4;
                valid_i = 1'b1;
                exp_q.push_back({1'b1, ~^8'hF4, 8'hF4, 1'b0});
                res_q.push_back(2'b10);
                @(posedge clk);
                #1 data_i = 8'h00;
                exp_q.push_back({1'b1, ~^8'h00, 8'h00, 1'b0});
                res_q.push_back(2'b10);
                n = 0;
                @(negedge clk);
                while (!ready_o && n < 5000) begin
                    @(negedge clk);
                    n++;
                end
                @(posedge clk);
                #1 valid_i = 1'b0;
            end
            begin
                device_frame(1'b0);
                device_frame(1'b0);
            end
        join

        // NAK: ACK sampled high
        send_byte(8'h5A, 2'b01, 1, 1);
        device_frame(1'b1);
        check_eq("nak_state_idle", {31'b0, ready_o}, 32'd1);

        // timeout: device never clocks
        send_byte(8'hC3, 2'b01, 0, 1);
        wait_release(hi, dcnt, dlast);
        check_eq("tmo_clk_oe_cycles", hi, INH + 1);
        n = 0;
        while (!err_o && n < TMO + 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("tmo_cycles", n, TMO);
        check_eq("tmo_oe", {30'b0, ps2_clk_oe_o, ps2_data_oe_o}, 32'd0);
        @(negedge clk);
        check_eq("tmo_ready", {31'b0, ready_o}, 32'd1);

        // reset after the 4th fall of a 0xAB frame
        send_byte(8'hAB, 2'b00, 0, 0);
        wait_release(hi, dcnt, dlast);
        repeat (HALF / 2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (i < 3) begin
                dev_clk_low = 1'b0;
                repeat (HALF) @(negedge clk);
            end
        end
        reset_i = 1'b1;
        @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_oe", {30'b0, ps2_clk_oe_o, ps2_data_oe_o}, 32'd0);
        check_eq("rst_mid_ready", {31'b0, ready_o}, 32'd1);
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
        send_byte(8'h55, 2'b10, 1, 1);
        device_frame(1'b0);

        // valid_i pulsed while busy: ignored
        send_byte(8'h3C, 2'b10, 1, 1);
        fork
            device_frame(1'b0);
            begin
                repeat (20) @(negedge clk);
                data_i  = 8'h99;
                valid_i = 1'b1;
                @(negedge clk);
                valid_i = 1'b0;
            end
        join
        extra = 0;
        repeat (300) begin
            @(negedge clk);
            if (ps2_clk_oe_o || busy_o) extra++;
        end
        check_eq("extra_frame", extra, 32'd0);

        check_eq("exp_q_empty", exp_q.size(), 32'd0);
        check_eq("res_q_empty", res_q.size(), 32'd0);
        check_eq("accept_count", n_acc, 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
